pc8001_keymatrix: RTL and testbench



---
 rtl/pc8001_keymatrix_pkg.sv | 40 ++++
 rtl/pc8001_keymatrix_if.sv | 19 +
 rtl/pc8001_keymatrix_keymap.sv | 120 ++++++++++++
 rtl/pc8001_keymatrix.sv | 80 ++++++++
 tb/tb_pc8001_keymatrix.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc8001_keymatrix_pkg.sv
// rtl/pc8001_keymatrix_pkg.sv - shared types and named matrix positions for the PC-8001 keyboard matrix
package pc8001_kbd_pkg;

  // Largest row space addressable by the 4-bit read port
  localparam int ROWS_MAX = 16;

  // Lookup result: hit = code is mapped, row/col = matrix position
  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } kpos_t;

  // Captured key event, bit order matches ps2_key[9:0]
  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] code;
  } kev_t;

  localparam logic [3:0] STOP_ROW  = 4'd9;
  localparam logic [2:0] STOP_COL  = 3'd0;
  localparam logic [3:0] SHIFT_ROW = 4'd8;
  localparam logic [2:0] SHIFT_COL = 3'd6;
  localparam logic [3:0] CTRL_ROW  = 4'd8;
  localparam logic [2:0] CTRL_COL  = 3'd7;
  localparam logic [3:0] KANA_ROW  = 4'd8;
  localparam logic [2:0] KANA_COL  = 3'd5;
  localparam logic [3:0] GRPH_ROW  = 4'd8;
  localparam logic [2:0] GRPH_COL  = 3'd4;

  function automatic kpos_t kpos(input logic [3:0] r, input logic [2:0] c);
    kpos_t p;
    p.hit = 1'b1;
    p.row = r;
    p.col = c;
    return p;
  endfunction

endpackage

// File: rtl/pc8001_keymatrix_if.sv
// rtl/pc8001_keymatrix_if.sv - key event input and matrix read port bundle
interface pc8001_keymatrix_if;
  logic [10:0] ps2_key;
  logic        clear_all;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        key_stop;
  logic        key_any;

  modport master (
    output ps2_key, clear_all, rd_addr,
    input  rd_data, key_stop, key_any
  );

  modport slave (
    input  ps2_key, clear_all, rd_addr,
    output rd_data, key_stop, key_any
  );
endinterface

// File: rtl/pc8001_keymatrix_keymap.sv
// rtl/pc8001_keymatrix_keymap.sv - set-2 scancode to matrix position ROM; PC8001_KBD_NUMPAD_EN selects the ten-key mapping
module pc8001_keymap
  import pc8001_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output kpos_t      pos
);

  // Pure case ROM on {ext, code}; anything not listed is a miss
  always_comb begin
    pos = '0;
    case ({ext, code})
      9'h052: pos = kpos(4'd2, 3'd0);
      9'h01C: pos = kpos(4'd2, 3'd1);
      9'h032: pos = kpos(4'd2, 3'd2);
      9'h021: pos = kpos(4'd2, 3'd3);
      9'h023: pos = kpos(4'd2, 3'd4);
      9'h024: pos = kpos(4'd2, 3'd5);
      9'h02B: pos = kpos(4'd2, 3'd6);
      9'h034: pos = kpos(4'd2, 3'd7);
      9'h033: pos = kpos(4'd3, 3'd0);
      9'h043: pos = kpos(4'd3, 3'd1);
      9'h03B: pos = kpos(4'd3, 3'd2);
      9'h042: pos = kpos(4'd3, 3'd3);
      9'h04B: pos = kpos(4'd3, 3'd4);
      9'h03A: pos = kpos(4'd3, 3'd5);
      9'h031: pos = kpos(4'd3, 3'd6);
      9'h044: pos = kpos(4'd3, 3'd7);
      9'h04D: pos = kpos(4'd4, 3'd0);
      9'h015: pos = kpos(4'd4, 3'd1);
      9'h02D: pos = kpos(4'd4, 3'd2);
      9'h01B: pos = kpos(4'd4, 3'd3);
      9'h02C: pos = kpos(4'd4, 3'd4);
      9'h03C: pos = kpos(4'd4, 3'd5);
      9'h02A: pos = kpos(4'd4, 3'd6);
      9'h01D: pos = kpos(4'd4, 3'd7);
      9'h022: pos = kpos(4'd5, 3'd0);
      9'h035: pos = kpos(4'd5, 3'd1);
      9'h01A: pos = kpos(4'd5, 3'd2);
      9'h054: pos = kpos(4'd5, 3'd3);
      9'h05D: pos = kpos(4'd5, 3'd4);
      9'h05B: pos = kpos(4'd5, 3'd5);
      9'h055: pos = kpos(4'd5, 3'd6);
      9'h04E: pos = kpos(4'd5, 3'd7);
      9'h045: pos = kpos(4'd6, 3'd0);
      9'h016: pos = kpos(4'd6, 3'd1);
      9'h01E: pos = kpos(4'd6, 3'd2);
      9'h026: pos = kpos(4'd6, 3'd3);
      9'h025: pos = kpos(4'd6, 3'd4);
      9'h02E: pos = kpos(4'd6, 3'd5);
      9'h036: pos = kpos(4'd6, 3'd6);
      9'h03D: pos = kpos(4'd6, 3'd7);
      9'h03E: pos = kpos(4'd7, 3'd0);
      9'h046: pos = kpos(4'd7, 3'd1);
      9'h04C: pos = kpos(4'd7, 3'd3);
      9'h041: pos = kpos(4'd7, 3'd4);
      9'h049: pos = kpos(4'd7, 3'd5);
      9'h04A: pos = kpos(4'd7, 3'd6);
      9'h061: pos = kpos(4'd7, 3'd7);
      9'h16C: pos = kpos(4'd8, 3'd0);
      9'h175: pos = kpos(4'd8, 3'd1);
      9'h174: pos = kpos(4'd8, 3'd2);
      9'h066: pos = kpos(4'd8, 3'd3);
      9'h170: pos = kpos(4'd8, 3'd3);
      9'h171: pos = kpos(4'd8, 3'd3);
      9'h011: pos = kpos(GRPH_ROW, GRPH_COL);
      9'h111: pos = kpos(GRPH_ROW, GRPH_COL);
      9'h058: pos = kpos(KANA_ROW, KANA_COL);
      // Both shifts share one matrix bit; either break releases it
      9'h012: pos = kpos(SHIFT_ROW, SHIFT_COL);
      9'h059: pos = kpos(SHIFT_ROW, SHIFT_COL);
      9'h014: pos = kpos(CTRL_ROW, CTRL_COL);
      9'h114: pos = kpos(CTRL_ROW, CTRL_COL);
      9'h169: pos = kpos(STOP_ROW, STOP_COL);
      9'h005: pos = kpos(4'd9, 3'd1);
      9'h006: pos = kpos(4'd9, 3'd2);
      9'h004: pos = kpos(4'd9, 3'd3);
      9'h00C: pos = kpos(4'd9, 3'd4);
      9'h003: pos = kpos(4'd9, 3'd5);
      9'h029: pos = kpos(4'd9, 3'd6);
      9'h076: pos = kpos(4'd9, 3'd7);
      9'h05A: pos = kpos(4'd1, 3'd7);
      9'h15A: pos = kpos(4'd1, 3'd7);
`ifdef PC8001_KBD_NUMPAD_EN
      // Keypad feeds the dedicated ten-key rows; E0 variants stay arrows
      9'h070: pos = kpos(4'd0, 3'd0);
      9'h069: pos = kpos(4'd0, 3'd1);
      9'h072: pos = kpos(4'd0, 3'd2);
      9'h07A: pos = kpos(4'd0, 3'd3);
      9'h06B: pos = kpos(4'd0, 3'd4);
      9'h073: pos = kpos(4'd0, 3'd5);
      9'h074: pos = kpos(4'd0, 3'd6);
      9'h06C: pos = kpos(4'd0, 3'd7);
      9'h075: pos = kpos(4'd1, 3'd0);
      9'h07D: pos = kpos(4'd1, 3'd1);
      9'h07C: pos = kpos(4'd1, 3'd2);
      9'h079: pos = kpos(4'd1, 3'd3);
      9'h071: pos = kpos(4'd1, 3'd6);
`else
      // Keypad aliases onto the main-row digits and punctuation
      9'h070: pos = kpos(4'd6, 3'd0);
      9'h069: pos = kpos(4'd6, 3'd1);
      9'h072: pos = kpos(4'd6, 3'd2);
      9'h07A: pos = kpos(4'd6, 3'd3);
      9'h06B: pos = kpos(4'd6, 3'd4);
      9'h073: pos = kpos(4'd6, 3'd5);
      9'h074: pos = kpos(4'd6, 3'd6);
      9'h06C: pos = kpos(4'd6, 3'd7);
      9'h075: pos = kpos(4'd7, 3'd0);
      9'h07D: pos = kpos(4'd7, 3'd1);
      9'h07C: pos = kpos(4'd7, 3'd2);
      9'h079: pos = kpos(4'd7, 3'd3);
      9'h071: pos = kpos(4'd7, 3'd5);
`endif
      default: pos = '0;
    endcase
  end

endmodule

// File: rtl/pc8001_keymatrix.sv
// rtl/pc8001_keymatrix.sv - ps2_key event pipeline into the PC-8001 10x8 key matrix with a registered row read port
module pc8001_keymatrix
  import pc8001_kbd_pkg::*;
#(
  parameter int ROWS = 10
) (
  input logic                clk_sys,
  input logic                reset,
  pc8001_keymatrix_if.slave  bus
);

  logic [10:0]                key_q;
  logic                       tog_q;
  kev_t                       ev0;
  logic                       v0;
  kpos_t                      map_pos;
  kpos_t                      ev1_pos;
  logic                       ev1_make;
  logic                       v1;
  logic [ROWS_MAX-1:0][7:0]   matrix;

  pc8001_keymap u_keymap (
    .ext  (ev0.ext),
    .code (ev0.code),
    .pos  (map_pos)
  );

  // S0: register the input, detect a toggle edge and capture the event
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q <= bus.ps2_key;
      tog_q <= bus.ps2_key[10];
      v0    <= 1'b0;
      ev0   <= '0;
    end else begin
      key_q <= bus.ps2_key;
      v0    <= (key_q[10] != tog_q);
      if (key_q[10] != tog_q) begin
        tog_q <= key_q[10];
        ev0   <= kev_t'(key_q[9:0]);
      end
    end
  end

  // S1: register the keymap lookup result alongside make/break
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      v1       <= 1'b0;
      ev1_pos  <= '0;
      ev1_make <= 1'b0;
    end else begin
      v1       <= v0;
      ev1_pos  <= map_pos;
      ev1_make <= ev0.make;
    end
  end

  // S2: apply the event to the matrix; clear_all overrides a coinciding apply
  always_ff @(posedge clk_sys) begin
    if (reset || bus.clear_all) begin
      matrix <= '0;
    end else if (v1 && ev1_pos.hit && (32'(ev1_pos.row) < ROWS)) begin
      matrix[ev1_pos.row][ev1_pos.col] <= ev1_make;
    end
  end

  // Read port and status flags, all registered from the pre-write matrix
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.rd_data  <= 8'hFF;
      bus.key_stop <= 1'b0;
      bus.key_any  <= 1'b0;
    end else begin
      bus.rd_data  <= (32'(bus.rd_addr) < ROWS) ? ~matrix[bus.rd_addr] : 8'hFF;
      bus.key_stop <= matrix[STOP_ROW][STOP_COL];
      bus.key_any  <= |matrix;
    end
  end

endmodule

// File: tb/tb_pc8001_keymatrix.sv
// tb/tb_pc8001_keymatrix.sv - directed and randomized checks of pc8001_keymatrix against a key-table model
module tb_pc8001_keymatrix;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc8001_keymatrix_if bus ();

  pc8001_keymatrix #(.ROWS(10)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  int compares = 0;
  int errors   = 0;

  logic [7:0] model_row [16];

  // {ext, code, row, col}
  logic [15:0] tbl [16] = '{
    {1'b0, 8'h1C, 4'd2, 3'd1},
    {1'b0, 8'h1A, 4'd5, 3'd2},
    {1'b0, 8'h12, 4'd8, 3'd6},
    {1'b0, 8'h59, 4'd8, 3'd6},
    {1'b0, 8'h14, 4'd8, 3'd7},
    {1'b1, 8'h75, 4'd8, 3'd1},
    {1'b0, 8'h29, 4'd9, 3'd6},
    {1'b0, 8'h76, 4'd9, 3'd7},
    {1'b0, 8'h05, 4'd9, 3'd1},
    {1'b0, 8'h16, 4'd6, 3'd1},
    {1'b0, 8'h5A, 4'd1, 3'd7},
    {1'b1, 8'h69, 4'd9, 3'd0},
    {1'b0, 8'h32, 4'd2, 3'd2},
    {1'b0, 8'h45, 4'd6, 3'd0},
`ifdef PC8001_KBD_NUMPAD_EN
    {1'b0, 8'h75, 4'd1, 3'd0},
    {1'b0, 8'h69, 4'd0, 3'd1}
`else
    {1'b0, 8'h75, 4'd7, 3'd0},
    {1'b0, 8'h69, 4'd6, 3'd1}
`endif
  };

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_row[i] = 8'h00;
  endtask

  task automatic model_apply(input logic make, input logic ext, input logic [7:0] code);
    logic [15:0] e;
    for (int i = 0; i < 16; i++) begin
      e = tbl[i];
      if (e[15] == ext && e[14:7] == code) model_row[e[6:3]][e[2:0]] = make;
    end
  endtask

  function automatic logic model_any();
    logic a = 1'b0;
    for (int i = 0; i < 16; i++) a = a | (|model_row[i]);
    return a;
  endfunction

  task automatic send(input logic make, input logic ext, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], make, ext, code};
    model_apply(make, ext, code);
    tick(1);
  endtask

  task automatic clear_pulse();
    bus.clear_all = 1'b1;
    model_clear();
    tick(1);
    bus.clear_all = 1'b0;
    tick(1);
  endtask

  task automatic chk_rd(input string tag, input int a, input logic [7:0] exp);
    bus.rd_addr = 4'(a);
    tick(1);
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 16; a++) chk_rd($sformatf("%s_r%0d", tag, a), a, ~model_row[a]);
    chk({tag, "_any"}, 8'(bus.key_any), 8'(model_any()));
    chk({tag, "_stop"}, 8'(bus.key_stop), 8'(model_row[9][0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.ps2_key   = 11'h000;
    bus.clear_all = 1'b0;
    bus.rd_addr   = 4'd0;
    model_clear();
    tick(3);
    reset = 1'b0;
    tick(2);
    check_all("reset");

    // Toggle in the first post-reset cycle; exact four-edge visibility
    reset = 1'b1;
    tick(2);
    reset       = 1'b0;
    bus.rd_addr = 4'd2;
    bus.ps2_key = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h1C};
    model_clear();
    model_apply(1'b1, 1'b0, 8'h1C);
    tick(4);
    chk("t1_edge3", bus.rd_data, 8'hFF);
    tick(1);
    chk("t1_edge4", bus.rd_data, 8'hFD);
    chk("t1_any", 8'(bus.key_any), 8'h01);

    // Back-to-back events, then a shift break
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h1A);
    send(1'b1, 1'b0, 8'h12);
    tick(4);
    chk_rd("t2_r2", 2, 8'hFD);
    chk_rd("t2_r5", 5, 8'hFB);
    chk_rd("t2_r8", 8, 8'hBF);
    send(1'b0, 1'b0, 8'h12);
    tick(4);
    chk_rd("t2_r8_brk", 8, 8'hFF);
    chk_rd("t2_r2_keep", 2, 8'hFD);
    chk_rd("t2_r5_keep", 5, 8'hFB);

    // Arrow versus keypad 8
    send(1'b1, 1'b1, 8'h75);
    tick(4);
    chk_rd("t3_up", 8, 8'hFD);
    send(1'b1, 1'b0, 8'h75);
    tick(4);
`ifdef PC8001_KBD_NUMPAD_EN
    chk_rd("t3_kp8", 1, 8'hFE);
`else
    chk_rd("t3_kp8", 7, 8'hFE);
`endif

    // STOP key timing
    send(1'b1, 1'b1, 8'h69);
    tick(3);
    chk("t4_stop_early", 8'(bus.key_stop), 8'h00);
    tick(1);
    chk("t4_stop", 8'(bus.key_stop), 8'h01);
    chk_rd("t4_r9", 9, 8'hFE);
    send(1'b0, 1'b1, 8'h69);
    tick(5);
    chk("t4_stop_brk", 8'(bus.key_stop), 8'h00);
    chk_rd("t4_r9_brk", 9, 8'hFF);

    clear_pulse();
    chk("clr_any", 8'(bus.key_any), 8'h00);
    chk_rd("clr_r2", 2, 8'hFF);

    // clear_all coinciding with the S2 apply wins
    send(1'b1, 1'b0, 8'h29);
    tick(2);
    bus.clear_all = 1'b1;
    model_clear();
    tick(1);
    bus.clear_all = 1'b0;
    tick(2);
    chk_rd("t5_r9", 9, 8'hFF);
    tick(5);
    chk_rd("t5_r9_stay", 9, 8'hFF);
    chk("t5_any", 8'(bus.key_any), 8'h00);

    // An event still in S0/S1 survives an earlier clear
    send(1'b1, 1'b0, 8'h1C);
    bus.clear_all = 1'b1;
    tick(1);
    bus.clear_all = 1'b0;
    tick(4);
    chk_rd("t5_inflight", 2, 8'hFD);

    // Unmapped code leaves the matrix alone
    send(1'b1, 1'b0, 8'h0E);
    tick(5);
    check_all("t5_unmapped");

    // Reset one cycle after a toggle discards the event
    clear_pulse();
    send(1'b1, 1'b0, 8'h1A);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      chk_rd($sformatf("t6_r5_c%0d", i), 5, 8'hFF);
      chk($sformatf("t6_any_c%0d", i), 8'(bus.key_any), 8'h00);
    end
    check_all("t6");

    // Randomized bursts against the table model
    clear_pulse();
    for (int b = 0; b < 30; b++) begin
      int n;
      int a;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        logic [15:0] e;
        e = tbl[$urandom_range(0, 15)];
        send(1'($urandom_range(0, 1)), e[15], e[14:7]);
      end
      tick(4);
      chk($sformatf("rnd%0d_any", b), 8'(bus.key_any), 8'(model_any()));
      chk($sformatf("rnd%0d_stop", b), 8'(bus.key_stop), 8'(model_row[9][0]));
      a = $urandom_range(0, 15);
      chk_rd($sformatf("rnd%0d_r%0d", b, a), a, ~model_row[a]);
    end
    check_all("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
